// File: rtl/booth_radix4_mul_seq.sv
// ============================================================================
// Module   : booth_radix4_mul_seq
// Brief    : Sequential radix-4 Booth multiplier, one Booth digit per enabled
//            cycle, valid/ready on both sides, per-operation signed/unsigned.
//            Optional macro BOOTH_R4_EARLY_EXIT_EN: finish as soon as all
//            remaining Booth digits are zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_radix4_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clk_en_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  input  logic               signed_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int c_NDIG = WIDTH / 2 + 1;
  localparam int c_CW   = $clog2(c_NDIG + 1);
  localparam int c_PW   = WIDTH + 3;
  localparam int c_AW   = WIDTH + 2;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MULTIPLY = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_PW-1:0]        r_p;
  logic [c_AW-1:0]        r_a;
  logic                   r_l;
  logic [c_PW-1:0]        r_b;
  logic [c_CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]     r_result;

  logic                   w_accept;
  logic                   w_step;
  logic                   w_exit;
  logic [2:0]             w_digit;
  logic [c_PW-1:0]        w_b2;
  logic [c_PW-1:0]        w_addend;
  logic [c_PW-1:0]        w_sum;
  logic [c_PW+c_AW-1:0]   w_shifted;
  int                     w_shamt;
`ifdef BOOTH_R4_EARLY_EXIT_EN
  logic                   w_rem_zero;
  logic                   w_rem_ones;
`endif

  // Booth digit selection and one partial-product accumulation.
  always_comb begin
    w_digit = {r_a[1:0], r_l};
    w_b2    = {r_b[c_PW-2:0], 1'b0};
    case (w_digit)
      3'b001, 3'b010: w_addend = r_b;
      3'b011:         w_addend = w_b2;
      3'b100:         w_addend = -w_b2;
      3'b101, 3'b110: w_addend = -r_b;
      default:        w_addend = '0;
    endcase
    w_sum = r_p + w_addend;
  end

  // Shift distance is 2 per digit; early exit folds all remaining shifts in.
  always_comb begin
    w_exit  = (r_cnt == c_LAST);
    w_shamt = 2;
`ifdef BOOTH_R4_EARLY_EXIT_EN
    w_rem_zero = 1'b1;
    w_rem_ones = 1'b1;
    // After this step the unconsumed multiplier bits plus L are old A[top:1].
    for (int i = 1; i < c_AW; i++) begin
      if (i <= c_AW - 1 - 2 * int'(r_cnt)) begin
        w_rem_zero = w_rem_zero & ~r_a[i];
        w_rem_ones = w_rem_ones & r_a[i];
      end
    end
    if (w_rem_zero || w_rem_ones) begin
      w_exit  = 1'b1;
      w_shamt = 2 * (c_NDIG - int'(r_cnt));
    end
`endif
    w_shifted = $signed({w_sum, r_a}) >>> w_shamt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else if (clk_en_i) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MULTIPLY;
        end
      end
      S_MULTIPLY: begin
        w_step = 1'b1;
        if (w_exit) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands are extended at accept, so the mode needs no register of its own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_p      <= '0;
      r_a      <= '0;
      r_l      <= 1'b0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (clk_en_i) begin
      if (w_accept) begin
        r_p   <= '0;
        r_l   <= 1'b0;
        r_cnt <= '0;
        r_a   <= {{2{signed_i & multiplier_i[WIDTH-1]}}, multiplier_i};
        r_b   <= {{3{signed_i & multiplicand_i[WIDTH-1]}}, multiplicand_i};
      end else if (w_step) begin
        r_p   <= w_shifted[c_PW+c_AW-1 -: c_PW];
        r_a   <= w_shifted[c_AW-1:0];
        r_l   <= r_a[1];
        r_cnt <= r_cnt + c_CW'(1);
        if (w_exit) begin
          r_result <= w_shifted[2*WIDTH-1:0];
        end
      end
    end
  end

  assign result_o = r_result;

endmodule

`default_nettype wire
